// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types for the accumulator CPU control path.
//   opcode_e   - 4-bit instruction opcodes (IR[7:4])
//   bus_sel_e  - shared-bus source select encoding
//   state_e    - sequencer FSM states
//   ctrl_t     - packed bundle of every control strobe driven by the sequencer
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0,
    BUS_PC   = 3'd1,
    BUS_RAM  = 3'd2,
    BUS_IR   = 3'd3,
    BUS_ALU  = 3'd4,
    BUS_A    = 3'd5
  } bus_sel_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  typedef struct packed {
    bus_sel_e bus_sel;
    logic     mar_ld;
    logic     ir_ld;
    logic     a_ld;
    logic     b_ld;
    logic     out_ld;
    logic     flags_ld;
    logic     ram_we;
    logic     pc_inc;
    logic     pc_ld;
    logic     alu_sub;
  } ctrl_t;

  localparam logic [3:0] HALT_OPCODE = 4'hF;
  localparam ctrl_t      CTRL_IDLE   = ctrl_t'(13'd0);

  // Opcodes with no execute micro-steps finish at T1 (NOP and the undefined 9..D).
  function automatic logic fetch_only(input logic [3:0] op);
    logic r;
    case (op)
      4'h0, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpu_microcode_rom.sv
// cpu_microcode_rom: purely combinational microcode table.
// Ports:
//   opcode_i    - current opcode (from IR)
//   tstate_i    - current T-state (0..4)
//   carry_i     - registered carry flag, used by JC
//   zero_i      - registered zero flag, used by JZ
//   ctrl_o      - control strobes for this micro-step
//   last_step_o - this micro-step ends the instruction
module cpu_microcode_rom
  import cpu_pkg::*;
(
  input  logic [3:0] opcode_i,
  input  logic [2:0] tstate_i,
  input  logic       carry_i,
  input  logic       zero_i,
  output ctrl_t      ctrl_o,
  output logic       last_step_o
);

  // Micro-step decode: fetch steps are opcode independent, execute steps are not.
  always_comb begin
    ctrl_o      = CTRL_IDLE;
    last_step_o = 1'b0;
    case (tstate_i)
      3'd0: begin
        ctrl_o.bus_sel = BUS_PC;
        ctrl_o.mar_ld  = 1'b1;
      end
      3'd1: begin
        ctrl_o.bus_sel = BUS_RAM;
        ctrl_o.ir_ld   = 1'b1;
        ctrl_o.pc_inc  = 1'b1;
        last_step_o    = fetch_only(opcode_i);
      end
      3'd2: begin
        case (opcode_i)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ctrl_o.bus_sel = BUS_IR;
            ctrl_o.mar_ld  = 1'b1;
          end
          OP_LDI: begin
            ctrl_o.bus_sel = BUS_IR;
            ctrl_o.a_ld    = 1'b1;
            last_step_o    = 1'b1;
          end
          OP_JMP: begin
            ctrl_o.bus_sel = BUS_IR;
            ctrl_o.pc_ld   = 1'b1;
            last_step_o    = 1'b1;
          end
          OP_JC: begin
            // Not-taken branch still consumes T2 but drives nothing.
            if (carry_i) begin
              ctrl_o.bus_sel = BUS_IR;
              ctrl_o.pc_ld   = 1'b1;
            end else begin
              ctrl_o = CTRL_IDLE;
            end
            last_step_o = 1'b1;
          end
          OP_JZ: begin
            if (zero_i) begin
              ctrl_o.bus_sel = BUS_IR;
              ctrl_o.pc_ld   = 1'b1;
            end else begin
              ctrl_o = CTRL_IDLE;
            end
            last_step_o = 1'b1;
          end
          OP_OUT: begin
            ctrl_o.bus_sel = BUS_A;
            ctrl_o.out_ld  = 1'b1;
            last_step_o    = 1'b1;
          end
          default: begin
            // HLT ends here; fetch-only opcodes never reach T2 but terminate safely.
            last_step_o = 1'b1;
          end
        endcase
      end
      3'd3: begin
        case (opcode_i)
          OP_LDA: begin
            ctrl_o.bus_sel = BUS_RAM;
            ctrl_o.a_ld    = 1'b1;
            last_step_o    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl_o.bus_sel = BUS_RAM;
            ctrl_o.b_ld    = 1'b1;
          end
          OP_STA: begin
            ctrl_o.bus_sel = BUS_A;
            ctrl_o.ram_we  = 1'b1;
            last_step_o    = 1'b1;
          end
          default: last_step_o = 1'b1;
        endcase
      end
      3'd4: begin
        case (opcode_i)
          OP_ADD, OP_SUB: begin
            ctrl_o.bus_sel  = BUS_ALU;
            ctrl_o.a_ld     = 1'b1;
            ctrl_o.flags_ld = 1'b1;
            ctrl_o.alu_sub  = (opcode_i == OP_SUB);
            last_step_o     = 1'b1;
          end
          default: last_step_o = 1'b1;
        endcase
      end
      default: last_step_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_control_sequencer.sv
// cpu_control_sequencer: microcoded T-state sequencer for the accumulator CPU.
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   run, single_step  - free-run enable, one-instruction step request pulse
//   ir_opcode         - opcode from IR (valid from T2)
//   carry_flag, zero_flag - registered ALU flags
//   bus_sel, *_ld, ram_we, pc_inc, pc_ld, alu_sub - datapath controls
//   halted            - processor stopped by HLT
//   instr_done        - last micro-step of the current instruction
//   tstate            - current T-state (debug)
module cpu_control_sequencer
  import cpu_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int STEP_W   = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                single_step,
  input  logic [OPCODE_W-1:0] ir_opcode,
  input  logic                carry_flag,
  input  logic                zero_flag,
  output logic [2:0]          bus_sel,
  output logic                mar_ld,
  output logic                ir_ld,
  output logic                a_ld,
  output logic                b_ld,
  output logic                out_ld,
  output logic                flags_ld,
  output logic                ram_we,
  output logic                pc_inc,
  output logic                pc_ld,
  output logic                alu_sub,
  output logic                halted,
  output logic                instr_done,
  output logic [STEP_W-1:0]   tstate
);

  state_e            state_q, state_d;
  logic [STEP_W-1:0] tstate_q, tstate_d;
  logic              step_req_q, step_req_d;

  logic  at_t0;
  logic  go;
  ctrl_t rom_ctrl;
  logic  rom_last;
  ctrl_t ctrl;
  logic  done;

  cpu_microcode_rom u_rom (
    .opcode_i    (ir_opcode),
    .tstate_i    (tstate_q),
    .carry_i     (carry_flag),
    .zero_i      (zero_flag),
    .ctrl_o      (rom_ctrl),
    .last_step_o (rom_last)
  );

  assign at_t0 = (state_q == ST_FETCH) && (tstate_q == STEP_W'(0));
  assign go    = run | step_req_q;

  // Next-state logic: boundary gating, T-state advance, step request bookkeeping.
  always_comb begin
    state_d    = state_q;
    tstate_d   = tstate_q;
    step_req_d = step_req_q;
    case (state_q)
      ST_FETCH, ST_EXEC: begin
        // A request is consumed only when an instruction actually starts.
        step_req_d = single_step | (step_req_q & ~(at_t0 & go));
        if (at_t0 && !go) begin
          tstate_d = tstate_q;
          state_d  = ST_FETCH;
        end else if (rom_last) begin
          tstate_d = STEP_W'(0);
          if ((state_q == ST_EXEC) && (ir_opcode == HALT_OPCODE)) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_FETCH;
          end
        end else begin
          tstate_d = tstate_q + STEP_W'(1);
          if (tstate_q == STEP_W'(1)) begin
            state_d = ST_EXEC;
          end else begin
            state_d = state_q;
          end
        end
      end
      ST_HALT: begin
        // Terminal: only reset leaves HALT, run/single_step are ignored.
        state_d    = ST_HALT;
        tstate_d   = STEP_W'(0);
        step_req_d = 1'b0;
      end
      default: begin
        state_d    = ST_FETCH;
        tstate_d   = STEP_W'(0);
        step_req_d = 1'b0;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      tstate_q   <= STEP_W'(0);
      step_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tstate_q   <= tstate_d;
      step_req_q <= step_req_d;
    end
  end

  // Output gating: reset, HALT and a paused boundary all silence the datapath.
  always_comb begin
    ctrl = CTRL_IDLE;
    done = 1'b0;
    if (reset) begin
      ctrl = CTRL_IDLE;
      done = 1'b0;
    end else if (state_q == ST_HALT) begin
      ctrl = CTRL_IDLE;
      done = 1'b0;
    end else if (at_t0 && !go) begin
      ctrl = CTRL_IDLE;
      done = 1'b0;
    end else begin
      ctrl = rom_ctrl;
      done = rom_last;
    end
  end

  assign bus_sel    = ctrl.bus_sel;
  assign mar_ld     = ctrl.mar_ld;
  assign ir_ld      = ctrl.ir_ld;
  assign a_ld       = ctrl.a_ld;
  assign b_ld       = ctrl.b_ld;
  assign out_ld     = ctrl.out_ld;
  assign flags_ld   = ctrl.flags_ld;
  assign ram_we     = ctrl.ram_we;
  assign pc_inc     = ctrl.pc_inc;
  assign pc_ld      = ctrl.pc_ld;
  assign alu_sub    = ctrl.alu_sub;
  assign instr_done = done;
  assign halted     = (state_q == ST_HALT) && !reset;
  assign tstate     = tstate_q;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// tb_cpu_control_sequencer: directed stimulus with a scoreboard queue.
// Each cycle the stimulus pushes the hand-computed output vector; a monitor on
// the falling edge pops and compares it against the DUT outputs.
module tb_cpu_control_sequencer;

  logic       clk = 1'b1;
  logic       reset;
  logic       run;
  logic       single_step;
  logic [3:0] ir_opcode;
  logic       carry_flag;
  logic       zero_flag;
  logic [2:0] bus_sel;
  logic       mar_ld, ir_ld, a_ld, b_ld, out_ld, flags_ld;
  logic       ram_we, pc_inc, pc_ld, alu_sub, halted, instr_done;
  logic [2:0] tstate;

  int checks   = 0;
  int failures = 0;

  logic [17:0] exp_q[$];
  string       tag_q[$];

  // Strobe positions: mar ir a b out flags ram_we pc_inc pc_ld alu_sub halted instr_done
  localparam logic [11:0] S_NONE = 12'h000;
  localparam logic [11:0] S_MAR  = 12'h800;
  localparam logic [11:0] S_IR   = 12'h400;
  localparam logic [11:0] S_A    = 12'h200;
  localparam logic [11:0] S_B    = 12'h100;
  localparam logic [11:0] S_OUT  = 12'h080;
  localparam logic [11:0] S_FLG  = 12'h040;
  localparam logic [11:0] S_WE   = 12'h020;
  localparam logic [11:0] S_INC  = 12'h010;
  localparam logic [11:0] S_PLD  = 12'h008;
  localparam logic [11:0] S_SUB  = 12'h004;
  localparam logic [11:0] S_HLT  = 12'h002;
  localparam logic [11:0] S_DONE = 12'h001;

  cpu_control_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .single_step (single_step),
    .ir_opcode   (ir_opcode),
    .carry_flag  (carry_flag),
    .zero_flag   (zero_flag),
    .bus_sel     (bus_sel),
    .mar_ld      (mar_ld),
    .ir_ld       (ir_ld),
    .a_ld        (a_ld),
    .b_ld        (b_ld),
    .out_ld      (out_ld),
    .flags_ld    (flags_ld),
    .ram_we      (ram_we),
    .pc_inc      (pc_inc),
    .pc_ld       (pc_ld),
    .alu_sub     (alu_sub),
    .halted      (halted),
    .instr_done  (instr_done),
    .tstate      (tstate)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] mk(input logic [2:0] b, input logic [11:0] s, input logic [2:0] t);
    return {b, s, t};
  endfunction

  // Push one cycle's expectation and advance to just after the next rising edge.
  task automatic step(input string tag, input logic [17:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag);
    step({tag, "_t0"}, mk(3'd1, S_MAR, 3'd0));
    step({tag, "_t1"}, mk(3'd2, S_IR | S_INC, 3'd1));
  endtask

  // Monitor: compare DUT outputs against the oldest expectation each falling edge.
  initial begin
    logic [17:0] e;
    logic [17:0] act;
    string       t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        act = {bus_sel, mar_ld, ir_ld, a_ld, b_ld, out_ld, flags_ld, ram_we,
               pc_inc, pc_ld, alu_sub, halted, instr_done, tstate};
        checks = checks + 1;
        if (act !== e) begin
          failures = failures + 1;
          $display("FAIL %s: actual=%05h expected=%05h", t, act, e);
        end
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset       = 1'b1;
    run         = 1'b1;
    single_step = 1'b0;
    ir_opcode   = 4'h0;
    carry_flag  = 1'b0;
    zero_flag   = 1'b0;

    // Reset held two cycles with run=1: everything silent.
    step("rst0", mk(3'd0, S_NONE, 3'd0));
    step("rst1", mk(3'd0, S_NONE, 3'd0));
    reset = 1'b0;

    // LDI then OUT, three cycles each.
    ir_opcode = 4'h5;
    fetch("ldi");
    step("ldi_t2", mk(3'd3, S_A | S_DONE, 3'd2));
    ir_opcode = 4'hE;
    fetch("out");
    step("out_t2", mk(3'd5, S_OUT | S_DONE, 3'd2));

    // SUB: five cycles, alu_sub only at T4.
    ir_opcode = 4'h3;
    fetch("sub");
    step("sub_t2", mk(3'd3, S_MAR, 3'd2));
    step("sub_t3", mk(3'd2, S_B, 3'd3));
    step("sub_t4", mk(3'd4, S_A | S_FLG | S_SUB | S_DONE, 3'd4));

    // LDA while running.
    ir_opcode = 4'h1;
    fetch("lda");
    step("lda_t2", mk(3'd3, S_MAR, 3'd2));
    step("lda_t3", mk(3'd2, S_A | S_DONE, 3'd3));

    // STA.
    ir_opcode = 4'h4;
    fetch("sta");
    step("sta_t2", mk(3'd3, S_MAR, 3'd2));
    step("sta_t3", mk(3'd5, S_WE | S_DONE, 3'd3));

    // JMP.
    ir_opcode = 4'h6;
    fetch("jmp");
    step("jmp_t2", mk(3'd3, S_PLD | S_DONE, 3'd2));

    // NOP and an undefined opcode both finish at T1.
    ir_opcode = 4'h0;
    step("nop_t0", mk(3'd1, S_MAR, 3'd0));
    step("nop_t1", mk(3'd2, S_IR | S_INC | S_DONE, 3'd1));
    ir_opcode = 4'hA;
    step("undef_t0", mk(3'd1, S_MAR, 3'd0));
    step("undef_t1", mk(3'd2, S_IR | S_INC | S_DONE, 3'd1));

    // Conditional jumps, taken and not taken.
    ir_opcode  = 4'h7;
    carry_flag = 1'b0;
    fetch("jc0");
    step("jc0_t2", mk(3'd0, S_DONE, 3'd2));
    carry_flag = 1'b1;
    fetch("jc1");
    step("jc1_t2", mk(3'd3, S_PLD | S_DONE, 3'd2));
    ir_opcode  = 4'h8;
    carry_flag = 1'b0;
    zero_flag  = 1'b1;
    fetch("jz1");
    step("jz1_t2", mk(3'd3, S_PLD | S_DONE, 3'd2));
    zero_flag = 1'b0;
    fetch("jz0");
    step("jz0_t2", mk(3'd0, S_DONE, 3'd2));

    // Pause at the boundary for ten cycles.
    run       = 1'b0;
    ir_opcode = 4'h1;
    for (int i = 0; i < 10; i++) begin
      step("pause", mk(3'd0, S_NONE, 3'd0));
    end
    // Step pulse: the pulse cycle itself is still idle, then one LDA runs.
    single_step = 1'b1;
    step("step_pulse", mk(3'd0, S_NONE, 3'd0));
    single_step = 1'b0;
    fetch("step_lda");
    step("step_lda_t2", mk(3'd3, S_MAR, 3'd2));
    step("step_lda_t3", mk(3'd2, S_A | S_DONE, 3'd3));
    step("repause0", mk(3'd0, S_NONE, 3'd0));
    step("repause1", mk(3'd0, S_NONE, 3'd0));

    // A pulse during T1 is held and releases exactly one more instruction.
    single_step = 1'b1;
    step("step2_pulse", mk(3'd0, S_NONE, 3'd0));
    single_step = 1'b0;
    step("step2_t0", mk(3'd1, S_MAR, 3'd0));
    single_step = 1'b1;
    step("step2_t1", mk(3'd2, S_IR | S_INC, 3'd1));
    single_step = 1'b0;
    step("step2_t2", mk(3'd3, S_MAR, 3'd2));
    step("step2_t3", mk(3'd2, S_A | S_DONE, 3'd3));
    ir_opcode = 4'h0;
    step("mid_nop_t0", mk(3'd1, S_MAR, 3'd0));
    step("mid_nop_t1", mk(3'd2, S_IR | S_INC | S_DONE, 3'd1));
    for (int i = 0; i < 3; i++) begin
      step("pause_after", mk(3'd0, S_NONE, 3'd0));
    end

    // HLT, then run/step toggling is ignored.
    run       = 1'b1;
    ir_opcode = 4'hF;
    fetch("hlt");
    step("hlt_t2", mk(3'd0, S_DONE, 3'd2));
    for (int i = 0; i < 4; i++) begin
      run         = i[0];
      single_step = ~i[0];
      step("halt_hold", mk(3'd0, S_HLT, 3'd0));
    end
    single_step = 1'b0;
    run         = 1'b1;

    // Reset leaves HALT.
    reset = 1'b1;
    step("halt_rst", mk(3'd0, S_NONE, 3'd0));
    reset = 1'b0;

    // ADD interrupted by reset in T3, then a full ADD.
    ir_opcode = 4'h2;
    fetch("add_a");
    step("add_a_t2", mk(3'd3, S_MAR, 3'd2));
    reset = 1'b1;
    step("add_rst_t3", mk(3'd0, S_NONE, 3'd0));
    step("add_rst_hold", mk(3'd0, S_NONE, 3'd0));
    reset = 1'b0;
    fetch("add_b");
    step("add_b_t2", mk(3'd3, S_MAR, 3'd2));
    step("add_b_t3", mk(3'd2, S_B, 3'd3));
    step("add_b_t4", mk(3'd4, S_A | S_FLG | S_DONE, 3'd4));
    step("after_add", mk(3'd1, S_MAR, 3'd0));

    // Every pushed expectation must have been consumed by the monitor.
    @(negedge clk);
    #1;
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL scoreboard_drain: actual=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
